// File: rtl/barrel_launcher.sv
`default_nettype none
// ============================================================================
// Module  : barrel_launcher
// Purpose : Kong throw sequencer - wind-up, one-shot slot start, cooldown,
//           slot occupancy tracking and hit aggregation for barrel movers.
// Revision: 1.0  initial release
// ============================================================================
module barrel_launcher #(
  parameter int N_BARRELS       = 2,
  parameter int THROW_CYCLES    = 6_500_000,
  parameter int COOLDOWN_CYCLES = 32_500_000,
  parameter int CNT_W           = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 game_en,
  input  logic                 throw_req,
  input  logic [N_BARRELS-1:0] barrel_done,
  input  logic [N_BARRELS-1:0] barrel_hit,
  output logic [N_BARRELS-1:0] barrel_start,
  output logic                 kong_throw,
  output logic                 ready,
  output logic [3:0]           active_cnt,
  output logic                 hit_pulse,
  output logic [7:0]           hit_count
);

  localparam int                   SEL_W        = (N_BARRELS > 1) ? $clog2(N_BARRELS) : 1;
  localparam logic [CNT_W-1:0]     C_THROW_LAST = CNT_W'(THROW_CYCLES - 1);
  localparam logic [CNT_W-1:0]     C_COOL_LAST  = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [N_BARRELS-1:0] C_ALL_BUSY   = '1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WINDUP   = 2'd1,
    ST_RELEASE  = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_timer;
  logic [CNT_W-1:0]     w_timer_nxt;
  logic [SEL_W-1:0]     r_sel;
  logic [SEL_W-1:0]     w_sel_nxt;
  logic [SEL_W-1:0]     w_free_idx;
  logic [N_BARRELS-1:0] r_busy;
  logic [N_BARRELS-1:0] w_busy_nxt;
  logic [N_BARRELS-1:0] r_done_q;
  logic [N_BARRELS-1:0] r_hit_q;
  logic [N_BARRELS-1:0] w_done_rise;
  logic [N_BARRELS-1:0] w_hit_rise;
  logic [N_BARRELS-1:0] w_slot_free;
  logic [N_BARRELS-1:0] w_sel_onehot;
  logic [N_BARRELS-1:0] r_start;
  logic [3:0]           w_pop;
  logic [3:0]           r_active;
  logic [7:0]           r_hit_count;
  logic                 r_ready;
  logic                 r_kong;
  logic                 r_hit_pulse;
  logic                 w_accept;
  logic                 w_ready_nxt;

  // A hit leaves the barrel rolling, so only a clean done frees its slot.
  always_comb begin
    w_done_rise  = barrel_done & ~r_done_q;
    w_hit_rise   = barrel_hit & ~r_hit_q;
    w_slot_free  = w_done_rise & ~barrel_hit;
    w_sel_onehot = N_BARRELS'(1) << r_sel;
  end

  always_comb begin
    w_free_idx = '0;
    for (int i = N_BARRELS - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N_BARRELS; i++) begin
      w_pop = w_pop + 4'(r_busy[i]);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_sel_nxt   = r_sel;
    w_busy_nxt  = r_busy & ~w_slot_free;
    w_accept    = r_ready & game_en & throw_req;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_sel_nxt   = w_free_idx;
          w_timer_nxt = '0;
          w_state_nxt = ST_WINDUP;
        end
      end
      ST_WINDUP: begin
        if (!game_en) begin
          w_timer_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_timer == C_THROW_LAST) begin
          w_state_nxt = ST_RELEASE;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      ST_RELEASE: begin
        w_busy_nxt  = w_busy_nxt | w_sel_onehot;
        w_timer_nxt = '0;
        w_state_nxt = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (r_timer == C_COOL_LAST) begin
          w_timer_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: begin
        w_timer_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Uses the registered busy vector: a slot freed at cycle t is offered at t+2.
    w_ready_nxt = (w_state_nxt == ST_IDLE) & game_en & (r_busy != C_ALL_BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_sel       <= '0;
      r_busy      <= '0;
      r_done_q    <= '0;
      r_hit_q     <= '0;
      r_ready     <= 1'b0;
      r_kong      <= 1'b0;
      r_start     <= '0;
      r_active    <= '0;
      r_hit_pulse <= 1'b0;
      r_hit_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_sel       <= w_sel_nxt;
      r_busy      <= w_busy_nxt;
      r_done_q    <= barrel_done;
      r_hit_q     <= barrel_hit;
      r_ready     <= w_ready_nxt;
      r_kong      <= (w_state_nxt == ST_WINDUP);
      r_start     <= (w_state_nxt == ST_RELEASE) ? w_sel_onehot : '0;
      r_active    <= w_pop;
      r_hit_pulse <= |w_hit_rise;
      if ((|w_hit_rise) && (r_hit_count != 8'hFF)) begin
        r_hit_count <= r_hit_count + 8'd1;
      end
    end
  end

  assign barrel_start = r_start;
  assign kong_throw   = r_kong;
  assign ready        = r_ready;
  assign active_cnt   = r_active;
  assign hit_pulse    = r_hit_pulse;
  assign hit_count    = r_hit_count;

endmodule
`default_nettype wire

// File: tb/tb_barrel_launcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_barrel_launcher
// Purpose : Directed and random checks of barrel_launcher against a
//           phase/countdown reference model.
// Revision: 1.0  initial release
// ============================================================================
module tb_barrel_launcher;

  localparam int N  = 2;
  localparam int TC = 4;
  localparam int CC = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         game_en;
  logic         throw_req;
  logic [N-1:0] barrel_done;
  logic [N-1:0] barrel_hit;
  logic [N-1:0] barrel_start;
  logic         kong_throw;
  logic         ready;
  logic [3:0]   active_cnt;
  logic         hit_pulse;
  logic [7:0]   hit_count;

  always #5 clk = ~clk;

  barrel_launcher #(
    .N_BARRELS       (N),
    .THROW_CYCLES    (TC),
    .COOLDOWN_CYCLES (CC),
    .CNT_W           (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .game_en      (game_en),
    .throw_req    (throw_req),
    .barrel_done  (barrel_done),
    .barrel_hit   (barrel_hit),
    .barrel_start (barrel_start),
    .kong_throw   (kong_throw),
    .ready        (ready),
    .active_cnt   (active_cnt),
    .hit_pulse    (hit_pulse),
    .hit_count    (hit_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_start_cyc = -1;
  logic [N-1:0] last_start_val = '0;

  // Reference model: launcher phase plus remaining-cycle countdown.
  typedef enum {M_IDLE, M_WIND, M_REL, M_COOL} mphase_t;
  mphase_t      m_phase = M_IDLE;
  int           m_left  = 0;
  int           m_sel   = 0;
  logic [N-1:0] m_busy  = '0;
  logic [N-1:0] m_dprev = '0;
  logic [N-1:0] m_hprev = '0;
  bit           m_ready = 1'b0;
  int           m_hits  = 0;
  logic [N-1:0] e_start = '0;
  bit           e_kong  = 1'b0;
  bit           e_pulse = 1'b0;
  int           e_active = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int lowest_free(input logic [N-1:0] b);
    for (int i = 0; i < N; i++) if (!b[i]) return i;
    return 0;
  endfunction

  task automatic model_step();
    logic [N-1:0] dr, hr, nb, old_busy;
    if (rst) begin
      m_phase = M_IDLE; m_left = 0; m_sel = 0; m_busy = '0;
      m_dprev = '0; m_hprev = '0; m_ready = 1'b0; m_hits = 0;
      e_start = '0; e_kong = 1'b0; e_pulse = 1'b0; e_active = 0;
      return;
    end
    dr       = barrel_done & ~m_dprev;
    hr       = barrel_hit & ~m_hprev;
    old_busy = m_busy;
    nb       = m_busy & ~(dr & ~barrel_hit);
    e_active = $countones(old_busy);
    e_pulse  = |hr;
    if ((|hr) && m_hits < 255) m_hits++;
    case (m_phase)
      M_IDLE: if (m_ready && game_en && throw_req) begin
        m_sel = lowest_free(old_busy); m_phase = M_WIND; m_left = TC;
      end
      M_WIND: if (!game_en) m_phase = M_IDLE;
              else begin m_left--; if (m_left == 0) m_phase = M_REL; end
      M_REL: begin nb[m_sel] = 1'b1; m_phase = M_COOL; m_left = CC; end
      M_COOL: begin m_left--; if (m_left == 0) m_phase = M_IDLE; end
    endcase
    m_ready = (m_phase == M_IDLE) && game_en && (old_busy != '1);
    m_busy  = nb;
    m_dprev = barrel_done;
    m_hprev = barrel_hit;
    e_kong  = (m_phase == M_WIND);
    e_start = (m_phase == M_REL) ? (N'(1) << m_sel) : '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    if (barrel_start != '0) begin
      last_start_val = barrel_start;
      last_start_cyc = cyc;
    end
    check("start",     32'(barrel_start), 32'(e_start));
    check("kong",      32'(kong_throw),   32'(e_kong));
    check("ready",     32'(ready),        32'(m_ready));
    check("active",    32'(active_cnt),   32'(e_active));
    check("hit_pulse", 32'(hit_pulse),    32'(e_pulse));
    check("hit_count", 32'(hit_count),    32'(m_hits));
  endtask

  initial begin
    int d;
    rst = 1'b1; game_en = 1'b0; throw_req = 1'b0; barrel_done = '0; barrel_hit = '0;
    repeat (2) tick();
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_ready",     32'(ready),     32'd0);
    rst = 1'b0; game_en = 1'b1;
    repeat (8) tick();

    // Single throw: wind-up, slot0 start, delayed active count, cooldown
    throw_req = 1'b1; tick();
    check("s1_kong_first", 32'(kong_throw), 32'd1);
    throw_req = 1'b0; repeat (3) tick();
    check("s1_kong_last", 32'(kong_throw), 32'd1);
    tick();
    check("s1_start", 32'(barrel_start), 32'd1);
    check("s1_kong_off", 32'(kong_throw), 32'd0);
    repeat (2) tick();
    check("s1_active", 32'(active_cnt), 32'd1);
    repeat (6) tick();
    check("s1_cool_ready", 32'(ready), 32'd0);
    tick();
    check("s1_ready_back", 32'(ready), 32'd1);

    // Held request fills slot0 then slot1, then stalls until a clean done
    barrel_done = 2'b01; tick(); barrel_done = '0; repeat (3) tick();
    throw_req = 1'b1;
    repeat (40) tick();
    check("s2_full_ready", 32'(ready), 32'd0);
    check("s2_full_kong",  32'(kong_throw), 32'd0);
    check("s2_full_cnt",   32'(active_cnt), 32'd2);
    d = cyc; barrel_done = 2'b01; tick(); barrel_done = '0;
    for (int k = 0; k < 40 && last_start_cyc <= d; k++) tick();
    check("s2_third_slot", 32'(last_start_val), 32'd1);
    check("s2_third_time", 32'(last_start_cyc), 32'(d + 2 + TC + 1));
    throw_req = 1'b0; repeat (15) tick();

    // Abort at second wind-up cycle
    barrel_done = 2'b10; tick(); barrel_done = '0; repeat (3) tick();
    throw_req = 1'b1; tick(); throw_req = 1'b0; tick();
    game_en = 1'b0; tick();
    check("s3_kong_abort", 32'(kong_throw), 32'd0);
    repeat (4) tick();
    check("s3_no_start", 32'(barrel_start), 32'd0);
    check("s3_busy_same", 32'(active_cnt), 32'd1);
    game_en = 1'b1; tick();
    check("s3_no_cooldown", 32'(ready), 32'd1);

    // Hit on slot1 keeps it busy; later clean done frees it
    throw_req = 1'b1; tick(); throw_req = 1'b0; repeat (15) tick();
    check("s4_both_busy", 32'(active_cnt), 32'd2);
    barrel_done = 2'b10; barrel_hit = 2'b10; tick();
    check("s4_hit_pulse", 32'(hit_pulse), 32'd1);
    check("s4_hit_count", 32'(hit_count), 32'd1);
    barrel_done = '0; barrel_hit = '0; repeat (3) tick();
    check("s4_still_busy", 32'(active_cnt), 32'd2);
    barrel_done = 2'b10; tick(); barrel_done = '0; repeat (2) tick();
    check("s4_freed", 32'(active_cnt), 32'd1);

    // Simultaneous hits count once; saturation at 255
    barrel_hit = 2'b11; tick();
    check("s5_single_pulse", 32'(hit_count), 32'd2);
    barrel_hit = '0; tick();
    for (int k = 0; k < 300; k++) begin
      barrel_hit = 2'b01; tick(); barrel_hit = '0; tick();
    end
    check("s5_saturate", 32'(hit_count), 32'd255);

    // Reset during cooldown with both slots busy
    throw_req = 1'b1; tick(); throw_req = 1'b0; repeat (4) tick();
    check("s6_start_slot1", 32'(barrel_start), 32'd2);
    repeat (2) tick();
    rst = 1'b1; tick();
    check("s6_rst_active", 32'(active_cnt), 32'd0);
    check("s6_rst_start",  32'(barrel_start), 32'd0);
    check("s6_rst_hits",   32'(hit_count), 32'd0);
    rst = 1'b0; tick();
    d = cyc; throw_req = 1'b1; tick(); throw_req = 1'b0;
    for (int k = 0; k < 10 && last_start_cyc <= d; k++) tick();
    check("s6_after_rst_slot0", 32'(last_start_val), 32'd1);
    repeat (12) tick();

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      rst       = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 29) == 0) game_en = ~game_en;
      throw_req = $urandom_range(0, 1) == 1;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) barrel_done[b] = ~barrel_done[b];
        barrel_hit[b] = ($urandom_range(0, 9) == 0);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/barrel_launcher.md
Name: barrel_launcher

Overview:
- Upstream stage of the horizontal barrel movers; one mover instance per barrel slot.
- Takes the Kong player's throw request and plays a wind-up phase on Kong's sprite.
- Issues a single-cycle start pulse to a free barrel slot, then enforces a cooldown before the next throw.
- Tracks slot occupancy from each mover's done/hit outputs and aggregates hits on Donkey for the game-state logic.

Parameters:
N_BARRELS, 2, number of barrel mover slots driven (1..8)
THROW_CYCLES, 6_500_000, wind-up length in clk cycles (0.1 s at 65 MHz)
COOLDOWN_CYCLES, 32_500_000, minimum gap after a release before next wind-up (0.5 s)
CNT_W, 26, timer width; must hold max(THROW_CYCLES, COOLDOWN_CYCLES)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
game_en  in  1  game running; low aborts wind-up and blocks throws
throw_req  in  1  Kong player throw button, level, already synchronised
barrel_done  in  N_BARRELS  done output of each barrel mover
barrel_hit  in  N_BARRELS  hit output of each barrel mover
barrel_start  out  N_BARRELS  one-cycle start pulse per slot (mover's barrel input)
kong_throw  out  1  high during wind-up; selects Kong throw sprite
ready  out  1  high when a throw would be accepted this cycle
active_cnt  out  4  number of busy slots
hit_pulse  out  1  one-cycle pulse per new hit on Donkey
hit_count  out  8  saturating total hit count

Behaviour:
- All outputs registered. Reset values: barrel_start=0, kong_throw=0, ready=0, active_cnt=0, hit_pulse=0, hit_count=0. State=ST_IDLE, busy=0, timer=0, done/hit history regs=0.
- Reset mid-operation frees all slots without pulsing barrel_start.
- Edge detect per slot: done_rise[i] = barrel_done[i] & ~done_q[i]; hit_rise likewise.
- Slot release: done_rise[i] with barrel_hit[i]=0 clears busy[i] next cycle.
- Hit handling: done_rise[i] with barrel_hit[i]=1 does not free the slot, because the barrel keeps rolling after a hit.
- Hit aggregation: any hit_rise makes hit_pulse=1 for one cycle and adds 1 to hit_count (not 1 per slot). hit_count saturates at 255.
- hit_rise in a slot with busy[i]=0 is still counted.
- FSM states:
  - ST_IDLE: ready = game_en & (busy != all ones). When ready & throw_req, latch sel = lowest-index free slot, timer=0, go to ST_WINDUP.
  - ST_WINDUP: kong_throw=1; timer increments each cycle. At timer == THROW_CYCLES-1, go to ST_RELEASE. game_en=0 aborts to ST_IDLE: no pulse, no cooldown.
  - ST_RELEASE: barrel_start[sel]=1 for exactly one cycle; busy[sel] set the same edge; timer cleared; go to ST_COOLDOWN. kong_throw=0.
  - ST_COOLDOWN: timer counts to COOLDOWN_CYCLES-1, then ST_IDLE. game_en drop does not shorten it.
- A held throw_req re-throws after each cooldown. No edge requirement on throw_req.
- Latency, throw_req to barrel_start: accepted in ST_IDLE at cycle t → kong_throw high t+1..t+THROW_CYCLES → barrel_start at cycle t+THROW_CYCLES+1.
- Slot reuse guard: a slot freed by done_rise at cycle t is first eligible at t+2. This guarantees the mover is idle with its fall counter cleared.
- Simultaneous release and free of the same slot in one cycle cannot occur, since sel was free. A free of another slot in the same cycle is applied normally.
- active_cnt = popcount(busy), registered, so it lags busy by one cycle.
- Timers never wrap. Compare is equality on CNT_W bits; THROW_CYCLES and COOLDOWN_CYCLES must be ≥1.

Test Plan (THROW_CYCLES=4, COOLDOWN_CYCLES=8, N_BARRELS=2):
- Reset, game_en=1, throw_req pulsed at cycle 10 → kong_throw high cycles 11..14; barrel_start=2'b01 at cycle 15 only; active_cnt=1 at cycle 17; next throw not accepted before cycle 24.
- throw_req held high → starts on slot0 then slot1. ready=0 and no further kong_throw until barrel_done[0] rises with hit=0. The third start goes to slot0 no earlier than 2 cycles after that rise.
- game_en dropped at 2nd wind-up cycle → kong_throw falls next cycle, barrel_start stays 0, busy unchanged, ST_IDLE with no cooldown.
- barrel_done[1] and barrel_hit[1] rise together → hit_pulse one cycle, hit_count +1, slot1 stays busy. A later done rise with hit=0 frees it.
- Both slots' hit rise in the same cycle → a single hit_pulse, hit_count +1. 300 hits → hit_count holds 255.
- rst asserted during ST_COOLDOWN with both slots busy → next cycle active_cnt, outputs and busy are all 0. The first throw after release lands on slot0.
